// File: rtl/debayer_pkg.sv
// Shared widths, RGGB site encoding and RGB pixel type for the bilinear demosaic stage.
package debayer_pkg;
  localparam int DEF_PIXEL_WIDTH    = 16;
  localparam int DEF_PIXELS_PER_CLK = 8;
  localparam int DEF_LINE_WORDS     = 96;
  localparam int DEF_WORD_WIDTH     = DEF_PIXEL_WIDTH * DEF_PIXELS_PER_CLK;

  typedef enum logic [1:0] {
    SITE_R,
    SITE_GR,
    SITE_GB,
    SITE_B
  } site_e;

  typedef struct packed {
    logic [DEF_PIXEL_WIDTH-1:0] r;
    logic [DEF_PIXEL_WIDTH-1:0] g;
    logic [DEF_PIXEL_WIDTH-1:0] b;
  } rgb_t;

  // Even rows are R G R G, odd rows G B G B; column 0 carries the row's first colour.
  function automatic site_e site_of(input logic row_odd, input logic col_odd);
    site_e s;
    case ({row_odd, col_odd})
      2'b00:   s = SITE_R;
      2'b01:   s = SITE_GR;
      2'b10:   s = SITE_GB;
      default: s = SITE_B;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/debayer_line_buffer.sv
// One-line store: single write port plus a registered read port (data one clock after rd_addr).
// No flow control of its own; contents are not reset.
module debayer_line_buffer
  import debayer_pkg::*;
#(
  parameter int DEPTH = DEF_LINE_WORDS,
  parameter int WIDTH = DEF_WORD_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
    rd_dat <= mem[rd_addr];
  end
endmodule

// File: rtl/debayer_filter_core.sv
// Bilinear RGGB demosaic emitting line N-1 while line N streams in; word j is registered after word j+1
// (or the line end) is accepted. A low data_valid_i inside a line freezes everything.
module debayer_filter_core
  import debayer_pkg::*;
#(
  parameter int PIXEL_WIDTH    = DEF_PIXEL_WIDTH,
  parameter int PIXELS_PER_CLK = DEF_PIXELS_PER_CLK,
  parameter int LINE_WORDS     = DEF_LINE_WORDS
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    line_valid_i,
  input  logic [PIXEL_WIDTH*PIXELS_PER_CLK-1:0]   data_i,
  input  logic                                    data_valid_i,
  output logic [3*PIXEL_WIDTH*PIXELS_PER_CLK-1:0] output_o,
  output logic                                    output_valid_o
);
  localparam int PW = PIXEL_WIDTH;
  localparam int NP = PIXELS_PER_CLK;
  localparam int WW = PW * NP;
  localparam int AW = $clog2(LINE_WORDS);
  localparam int CW = $clog2(LINE_WORDS + 1);

  logic              line_valid_q;
  logic              parity;
  logic [1:0]        line_cnt;
  logic [CW-1:0]     word_cnt;
  logic              take;
  logic              line_end;
  logic              emit;
  logic              first_word;
  logic [AW-1:0]     rd_addr;
  logic [WW-1:0]     rd_dat [2];
  logic [WW-1:0]     row_new  [3];
  logic [WW-1:0]     row_prev [3];
  logic [WW-1:0]     row_cur  [3];
  logic [PW-1:0]     ext [3][NP+2];
  logic [3*WW-1:0]   pix_out;

  function automatic logic [PW-1:0] px(input logic [WW-1:0] w, input int k);
    return w[WW-1-PW*k -: PW];
  endfunction

  function automatic logic [3*PW-1:0] interp(
    input site_e         site,
    input logic [PW-1:0] nw, input logic [PW-1:0] n,  input logic [PW-1:0] ne,
    input logic [PW-1:0] w,  input logic [PW-1:0] c,  input logic [PW-1:0] e,
    input logic [PW-1:0] sw, input logic [PW-1:0] s,  input logic [PW-1:0] se
  );
    logic [PW+1:0]   orth, diag, horz, vert;
    logic [PW-1:0]   m_orth, m_diag, m_horz, m_vert;
    logic [3*PW-1:0] res;
    orth   = {2'b00, n} + {2'b00, s} + {2'b00, w} + {2'b00, e};
    diag   = {2'b00, nw} + {2'b00, ne} + {2'b00, sw} + {2'b00, se};
    horz   = {2'b00, w} + {2'b00, e};
    vert   = {2'b00, n} + {2'b00, s};
    m_orth = PW'(orth >> 2);
    m_diag = PW'(diag >> 2);
    m_horz = PW'(horz >> 1);
    m_vert = PW'(vert >> 1);
    case (site)
      SITE_R:  res = {c, m_orth, m_diag};
      SITE_GR: res = {m_horz, c, m_vert};
      SITE_GB: res = {m_vert, c, m_horz};
      default: res = {m_diag, m_orth, c};
    endcase
    return res;
  endfunction

  assign take       = line_valid_i & data_valid_i & (word_cnt < CW'(LINE_WORDS));
  assign line_end   = line_valid_q & ~line_valid_i;
  assign emit       = (take | line_end) & (line_cnt != 2'd0) & (word_cnt != '0);
  assign first_word = (word_cnt == CW'(1));

  // parity doubles as the write-buffer select: the buffer being overwritten holds line N-2.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      line_valid_q <= 1'b0;
      parity       <= 1'b0;
      line_cnt     <= 2'd0;
      word_cnt     <= '0;
    end else begin
      line_valid_q <= line_valid_i;
      if (line_end) begin
        word_cnt <= '0;
        parity   <= ~parity;
        if (line_cnt != 2'd2) begin
          line_cnt <= line_cnt + 2'd1;
        end
      end else if (take) begin
        word_cnt <= word_cnt + CW'(1);
      end
    end
  end

  // Read one word ahead so the stored rows line up with data_i on the accepting edge.
  always_comb begin
    if (line_end) begin
      rd_addr = '0;
    end else if (word_cnt >= CW'(LINE_WORDS - 1)) begin
      rd_addr = AW'(LINE_WORDS - 1);
    end else if (take) begin
      rd_addr = AW'(word_cnt + CW'(1));
    end else begin
      rd_addr = AW'(word_cnt);
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    debayer_line_buffer #(
      .DEPTH (LINE_WORDS),
      .WIDTH (WW)
    ) u_buf (
      .clk     (clk_i),
      .wr_en   (take & (parity == 1'(b))),
      .wr_addr (AW'(word_cnt)),
      .wr_dat  (data_i),
      .rd_addr (rd_addr),
      .rd_dat  (rd_dat[b])
    );
  end

  // For centre row 0 the missing upper row mirrors to row 1, which is the incoming line.
  assign row_new[0] = (line_cnt == 2'd1) ? data_i : (parity ? rd_dat[1] : rd_dat[0]);
  assign row_new[1] = parity ? rd_dat[0] : rd_dat[1];
  assign row_new[2] = data_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int r = 0; r < 3; r++) begin
        row_prev[r] <= '0;
        row_cur[r]  <= '0;
      end
    end else if (take) begin
      for (int r = 0; r < 3; r++) begin
        row_prev[r] <= row_cur[r];
        row_cur[r]  <= row_new[r];
      end
    end
  end

  // Mirrored edges: column -1 takes column 1, column W takes column W-2.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NP; k++) begin
        ext[r][k+1] = px(row_cur[r], k);
      end
      ext[r][0]    = first_word ? px(row_cur[r], 1) : px(row_prev[r], NP - 1);
      ext[r][NP+1] = line_end ? px(row_cur[r], NP - 2) : px(row_new[r], 0);
    end
  end

  for (genvar k = 0; k < NP; k++) begin : g_pix
    site_e site;
    assign site = site_of(~parity, 1'(k % 2));
    assign pix_out[3*PW*(NP-k)-1 -: 3*PW] = interp(site,
      ext[0][k], ext[0][k+1], ext[0][k+2],
      ext[1][k], ext[1][k+1], ext[1][k+2],
      ext[2][k], ext[2][k+1], ext[2][k+2]);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      output_o       <= '0;
      output_valid_o <= 1'b0;
    end else begin
      output_valid_o <= emit;
      if (emit) begin
        output_o <= pix_out;
      end
    end
  end
endmodule

// File: tb/tb_debayer_filter_core.sv
// Randomised scoreboard bench for debayer_filter_core against a frame-level bilinear model.
module tb_debayer_filter_core;
  import debayer_pkg::*;

  localparam int MAXL  = 8;
  localparam int MAXPX = 768;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         line_valid_i;
  logic         data_valid_i;
  logic [127:0] data_i;
  logic [383:0] output_o;
  logic         output_valid_o;

  int checks = 0;
  int errors = 0;

  logic [15:0]  img [MAXL][MAXPX];
  int           cur_l;
  int           cur_wpx;
  int           exp_mode;
  rgb_t         const_pix;
  logic [383:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  debayer_filter_core dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .line_valid_i   (line_valid_i),
    .data_i         (data_i),
    .data_valid_i   (data_valid_i),
    .output_o       (output_o),
    .output_valid_o (output_valid_o)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic int smp(input int y, input int x);
    int yy;
    int xx;
    yy = y;
    xx = x;
    if (yy < 0) yy = -yy;
    if (yy >= cur_l) yy = 2 * (cur_l - 1) - yy;
    if (xx < 0) xx = -xx;
    if (xx >= cur_wpx) xx = 2 * (cur_wpx - 1) - xx;
    return int'(img[yy][xx]);
  endfunction

  function automatic rgb_t model_pix(input int y, input int x);
    int c, n, s, w, e, orth, diag, horz, vert;
    rgb_t p;
    c    = smp(y, x);
    n    = smp(y - 1, x);
    s    = smp(y + 1, x);
    w    = smp(y, x - 1);
    e    = smp(y, x + 1);
    orth = (n + s + w + e) / 4;
    diag = (smp(y - 1, x - 1) + smp(y - 1, x + 1) + smp(y + 1, x - 1) + smp(y + 1, x + 1)) / 4;
    horz = (w + e) / 2;
    vert = (n + s) / 2;
    if (y % 2 == 0 && x % 2 == 0) begin
      p.r = 16'(c);    p.g = 16'(orth); p.b = 16'(diag);
    end else if (y % 2 == 0) begin
      p.r = 16'(horz); p.g = 16'(c);    p.b = 16'(vert);
    end else if (x % 2 == 0) begin
      p.r = 16'(vert); p.g = 16'(c);    p.b = 16'(horz);
    end else begin
      p.r = 16'(diag); p.g = 16'(orth); p.b = 16'(c);
    end
    return p;
  endfunction

  function automatic logic [383:0] exp_word(input int y, input int j);
    logic [383:0] v;
    rgb_t p;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      p = (exp_mode == 1) ? const_pix : model_pix(y, j * 8 + k);
      v[383-48*k -: 48] = p;
    end
    return v;
  endfunction

  function automatic logic [127:0] word_of(input int y, input int j);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[127-16*k -: 16] = img[y][j * 8 + k];
    return v;
  endfunction

  task automatic check(input string name, input logic [383:0] got, input logic [383:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin : monitor
    logic [383:0] want;
    forever begin
      @(posedge clk_i);
      #1;
      if (output_valid_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%h want=no_output", output_o);
        end else begin
          want = exp_q.pop_front();
          if (output_o !== want) begin
            errors++;
            $display("FAIL output_word got=%h want=%h", output_o, want);
          end
        end
      end
    end
  end

  // Called at a falling clock edge; leaves the DUT out of reset at a falling edge.
  task automatic do_reset();
    reset_i      = 1'b0;
    line_valid_i = 1'b0;
    data_valid_i = 1'b0;
    @(negedge clk_i);
    check("reset_valid", {383'b0, output_valid_o}, '0);
    check("reset_output", output_o, '0);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic fill_frame(input int pat, input int lines, input int words);
    cur_l   = lines;
    cur_wpx = words * 8;
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < cur_wpx; x++) begin
        case (pat)
          0:       img[y][x] = 16'h8000;
          1:       img[y][x] = (y % 2 == 0 && x % 2 == 0) ? 16'h1000 :
                               (y % 2 == 1 && x % 2 == 1) ? 16'h3000 : 16'h2000;
          2:       img[y][x] = 16'(x * 256);
          default: img[y][x] = 16'($urandom);
        endcase
      end
    end
    exp_mode = (pat < 2) ? 1 : 0;
    if (pat == 0) const_pix = '{16'h8000, 16'h8000, 16'h8000};
    else          const_pix = '{16'h1000, 16'h2000, 16'h3000};
  endtask

  task automatic send_line(input int y, input int words, input int extra, input int stall_pct,
                           input bit fixed_stall, input int abort_at, output bit aborted);
    int nst;
    aborted = 1'b0;
    for (int j = 0; j < words + extra; j++) begin
      if (j == abort_at) begin
        do_reset();
        aborted = 1'b1;
        return;
      end
      nst = (int'($urandom_range(99, 0)) < stall_pct) ? int'($urandom_range(3, 1)) : 0;
      if (fixed_stall && j == words / 2) nst = 3;
      repeat (nst) begin
        line_valid_i = 1'b1;
        data_valid_i = 1'b0;
        data_i       = {4{$urandom}};
        @(negedge clk_i);
      end
      line_valid_i = 1'b1;
      data_valid_i = 1'b1;
      data_i       = (j < words) ? word_of(y, j) : {4{$urandom}};
      if (y >= 1 && j >= 1 && j < words) exp_q.push_back(exp_word(y - 1, j - 1));
      @(negedge clk_i);
    end
    line_valid_i = 1'b0;
    data_valid_i = 1'($urandom_range(1, 0));
    if (y >= 1) exp_q.push_back(exp_word(y - 1, words - 1));
    repeat ($urandom_range(3, 1)) begin
      @(negedge clk_i);
      data_valid_i = 1'($urandom_range(1, 0));
    end
  endtask

  task automatic run_frame(input int pat, input int lines, input int words, input int extra,
                           input int stall_pct, input bit fixed_stall,
                           input int abort_line, input int abort_word);
    bit ab;
    fill_frame(pat, lines, words);
    for (int y = 0; y < lines; y++) begin
      send_line(y, words, extra, stall_pct, fixed_stall, (y == abort_line) ? abort_word : -1, ab);
      if (ab) break;
    end
    repeat (4) @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
    do_reset();
  endtask

  initial begin
    reset_i      = 1'b0;
    line_valid_i = 1'b0;
    data_valid_i = 1'b0;
    data_i       = '0;
    repeat (2) @(negedge clk_i);
    do_reset();

    run_frame(0, 4, 96, 0, 0, 1'b0, -1, -1);
    run_frame(1, 4, 96, 0, 0, 1'b0, -1, -1);
    run_frame(2, 4, 16, 0, 0, 1'b1, -1, -1);
    run_frame(3, 5, 96, 3, 20, 1'b0, -1, -1);
    run_frame(3, 4, 37, 0, 25, 1'b0, -1, -1);
    run_frame(3, 3, 1, 0, 30, 1'b0, -1, -1);
    run_frame(3, 3, 2, 0, 30, 1'b0, -1, -1);
    run_frame(3, 6, int'($urandom_range(96, 3)), 0, 15, 1'b0, -1, -1);
    run_frame(3, 5, 24, 0, 10, 1'b0, 2, 10);
    run_frame(3, 4, 24, 0, 10, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
